// File: rtl/rename_unit.sv
// Register rename stage: speculative and committed RATs, a physical free list,
// lowest-index allocation, commit-time freeing and flush recovery.
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int ARCH_W    = $clog2(ARCH_REGS),
  parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rename_valid,
  output logic              rename_ready,
  input  logic [ARCH_W-1:0] rs1_arch,
  input  logic [ARCH_W-1:0] rs2_arch,
  input  logic [ARCH_W-1:0] rd_arch,
  input  logic              rd_wen,
  output logic [PHYS_W-1:0] rs1_phys,
  output logic [PHYS_W-1:0] rs2_phys,
  output logic [PHYS_W-1:0] rd_phys,
  output logic [PHYS_W-1:0] rd_old_phys,
  input  logic              commit_valid,
  input  logic [ARCH_W-1:0] commit_rd_arch,
  input  logic [PHYS_W-1:0] commit_rd_phys,
  input  logic [PHYS_W-1:0] commit_old_phys,
  input  logic              commit_wen,
  input  logic              flush,
  output logic [PHYS_W:0]   free_count
);

  localparam int RESET_FREE = PHYS_REGS - ARCH_REGS;

  logic [PHYS_W-1:0]    spec_rat [ARCH_REGS];
  logic [PHYS_W-1:0]    com_rat  [ARCH_REGS];
  logic [PHYS_REGS-1:0] free;
  logic [PHYS_REGS-1:0] com_used;

  logic [PHYS_REGS-1:0] free_next;
  logic [PHYS_REGS-1:0] com_used_next;
  logic [PHYS_W-1:0]    alloc_idx;
  logic                 alloc_found;
  logic                 need_alloc;
  logic                 alloc_fire;
  logic                 commit_fire;
  logic [PHYS_W:0]      pop_next;

  // Handshake: an instruction is consumed when rename_valid && rename_ready on a
  // rising clk edge; rename_ready never depends on rename_valid.
  assign rename_ready = !flush && (free_count != '0);
  assign need_alloc   = rd_wen && (rd_arch != '0);
  assign alloc_fire   = rename_valid && rename_ready && need_alloc;
  assign commit_fire  = commit_valid && commit_wen && (commit_rd_arch != '0);

  // Sources read the mapping as it stands before this instruction's own allocation.
  assign rs1_phys    = spec_rat[rs1_arch];
  assign rs2_phys    = spec_rat[rs2_arch];
  assign rd_old_phys = spec_rat[rd_arch];
  assign rd_phys     = need_alloc ? alloc_idx : '0;

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      if (!alloc_found && free[i]) begin
        alloc_idx   = PHYS_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    com_used_next = com_used;
    if (commit_fire) begin
      com_used_next[commit_rd_phys]  = 1'b1;
      com_used_next[commit_old_phys] = 1'b0;
    end
  end

  // Flush rebuilds the free list from the post-commit used set.
  always_comb begin
    free_next = free;
    if (flush) begin
      free_next = ~com_used_next;
    end else begin
      if (alloc_fire) free_next[alloc_idx] = 1'b0;
      if (commit_fire) free_next[commit_old_phys] = 1'b1;
    end
    free_next[0] = 1'b0;
  end

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      pop_next = pop_next + {{PHYS_W{1'b0}}, free_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PHYS_W'(i);
        com_rat[i]  <= PHYS_W'(i);
      end
      for (int i = 0; i < PHYS_REGS; i++) begin
        free[i]     <= (i >= ARCH_REGS);
        com_used[i] <= (i < ARCH_REGS);
      end
      free_count <= (PHYS_W+1)'(RESET_FREE);
    end else begin
      if (commit_fire) com_rat[commit_rd_arch] <= commit_rd_phys;
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          if (commit_fire && (commit_rd_arch == ARCH_W'(i)))
            spec_rat[i] <= commit_rd_phys;
          else
            spec_rat[i] <= com_rat[i];
        end
      end else if (alloc_fire) begin
        spec_rat[rd_arch] <= alloc_idx;
      end
      free       <= free_next;
      com_used   <= com_used_next;
      free_count <= pop_next;
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: lookups, allocation order, exhaustion,
// commit freeing, flush recovery and mid-stream reset.
module tb_rename_unit;

  logic       clk;
  logic       rst;
  logic       rename_valid;
  logic       rename_ready;
  logic [4:0] rs1_arch, rs2_arch, rd_arch;
  logic       rd_wen;
  logic [5:0] rs1_phys, rs2_phys, rd_phys, rd_old_phys;
  logic       commit_valid;
  logic [4:0] commit_rd_arch;
  logic [5:0] commit_rd_phys, commit_old_phys;
  logic       commit_wen;
  logic       flush;
  logic [6:0] free_count;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  rename_unit dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_ready(rename_ready),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch), .rd_wen(rd_wen),
    .rs1_phys(rs1_phys), .rs2_phys(rs2_phys), .rd_phys(rd_phys), .rd_old_phys(rd_old_phys),
    .commit_valid(commit_valid), .commit_rd_arch(commit_rd_arch),
    .commit_rd_phys(commit_rd_phys), .commit_old_phys(commit_old_phys),
    .commit_wen(commit_wen), .flush(flush), .free_count(free_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; every task returns at a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rename_valid = 0; rs1_arch = 0; rs2_arch = 0; rd_arch = 0; rd_wen = 0;
    commit_valid = 0; commit_rd_arch = 0; commit_rd_phys = 0; commit_old_phys = 0;
    commit_wen = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic lookup(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [5:0] e1, input logic [5:0] e2, input string tag);
    rs1_arch = a1; rs2_arch = a2;
    #1;
    check({tag, ".rs1"}, rs1_phys, e1);
    check({tag, ".rs2"}, rs2_phys, e2);
  endtask

  task automatic do_rename(input logic [4:0] rs1, input logic [4:0] rd, input logic wen,
                           input logic [5:0] e_rs1, input logic [5:0] e_rd,
                           input logic [5:0] e_old, input string tag);
    rename_valid = 1; rs1_arch = rs1; rs2_arch = 0; rd_arch = rd; rd_wen = wen;
    #1;
    check({tag, ".rs1"}, rs1_phys, e_rs1);
    check({tag, ".rd"}, rd_phys, e_rd);
    check({tag, ".old"}, rd_old_phys, e_old);
    step();
    rename_valid = 0; rd_wen = 0;
  endtask

  task automatic set_commit(input logic [4:0] a, input logic [5:0] p, input logic [5:0] old);
    commit_valid = 1; commit_wen = 1; commit_rd_arch = a;
    commit_rd_phys = p; commit_old_phys = old;
  endtask

  task automatic clear_commit();
    commit_valid = 0; commit_wen = 0; commit_rd_arch = 0;
    commit_rd_phys = 0; commit_old_phys = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);

    // reset state
    do_reset();
    lookup(5, 0, 5, 0, "rst_lookup");
    check("rst_free_count", free_count, 32);
    check("rst_ready", rename_ready, 1);

    // basic allocation and remap
    do_rename(0, 3, 1, 0, 32, 3, "ren3a");
    lookup(3, 0, 32, 0, "after_ren3a");
    check("cnt_after_ren3a", free_count, 31);
    do_rename(3, 3, 1, 32, 33, 32, "ren3b");
    check("cnt_after_ren3b", free_count, 30);

    // rs1==rd reads the old mapping; x0 destination allocates nothing
    do_reset();
    do_rename(7, 7, 1, 7, 32, 7, "ren7");
    do_rename(7, 0, 1, 32, 0, 0, "ren_x0");
    check("cnt_after_x0", free_count, 31);
    do_rename(0, 8, 1, 0, 33, 8, "ren8_after_x0");

    // exhaust the free list
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(32 + i);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      rename_valid = 1; rd_arch = 5'((i % 31) + 1); rd_wen = 1;
      #1;
      check($sformatf("burst_ready_%0d", i), rename_ready, 1);
      check($sformatf("burst_rd_%0d", i), rd_phys, e);
      step();
    end
    rename_valid = 0; rd_wen = 0;
    check("burst_cnt_empty", free_count, 0);
    check("burst_ready_low", rename_ready, 0);
    rename_valid = 1; rd_arch = 12; rd_wen = 1;
    #1;
    check("empty_rd_phys", rd_phys, 0);
    step();
    rename_valid = 0; rd_wen = 0;
    lookup(12, 0, 43, 0, "empty_no_fire");
    set_commit(3, 34, 3);
    #1;
    check("commit_cycle_cnt", free_count, 0);
    step();
    clear_commit();
    check("after_commit_cnt", free_count, 1);
    check("after_commit_ready", rename_ready, 1);
    do_rename(3, 10, 1, 34, 3, 41, "realloc3");
    check("realloc_cnt", free_count, 0);

    // partial commit then flush; rename and commit share a cycle
    do_reset();
    do_rename(0, 4, 1, 0, 32, 4, "ren4");
    set_commit(4, 32, 4);
    do_rename(0, 5, 1, 0, 33, 5, "ren5_with_commit");
    clear_commit();
    flush = 1;
    #1;
    check("flush_ready", rename_ready, 0);
    step();
    flush = 0;
    lookup(4, 5, 32, 5, "post_flush");
    check("post_flush_cnt", free_count, 32);
    do_rename(0, 9, 1, 0, 4, 9, "realloc4");
    do_rename(0, 10, 1, 0, 33, 10, "realloc33");

    // flush and commit in the same cycle
    do_reset();
    do_rename(0, 1, 1, 0, 32, 1, "ren1");
    do_rename(0, 2, 1, 0, 33, 2, "ren2");
    do_rename(0, 6, 1, 0, 34, 6, "ren6");
    set_commit(6, 34, 6);
    flush = 1;
    step();
    flush = 0;
    clear_commit();
    lookup(6, 1, 34, 1, "flush_commit_a");
    lookup(2, 0, 2, 0, "flush_commit_b");
    check("flush_commit_cnt", free_count, 32);
    do_rename(0, 8, 1, 0, 6, 8, "realloc6");
    do_rename(0, 9, 1, 0, 32, 9, "realloc32");

    // reset in the middle of a burst overrides a pending rename
    do_reset();
    do_rename(0, 1, 1, 0, 32, 1, "mid_ren1");
    do_rename(0, 2, 1, 0, 33, 2, "mid_ren2");
    rename_valid = 1; rd_arch = 3; rd_wen = 1; rst = 1;
    step();
    rst = 0; rename_valid = 0; rd_wen = 0;
    lookup(1, 2, 1, 2, "mid_rst_a");
    lookup(3, 0, 3, 0, "mid_rst_b");
    check("mid_rst_cnt", free_count, 32);
    do_rename(0, 1, 1, 0, 32, 1, "mid_rst_ren");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
